// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for pipeline hazard control: EX operand-mux select
// encodings and the hard-wired zero register index.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam int REG_X0 = 0;

endpackage

// File: rtl/hazard_track_slot.sv
// One tracking slot (EX, MEM or WB): remembers whether the stage holds a real
// instruction and what it will write back. Only the valid bit is reset; the
// payload is meaningless whenever valid is low.
module hazard_track_slot #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  clear,
    input  logic                  in_vld,
    input  logic                  in_we,
    input  logic                  in_is_load,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  vld,
    output logic                  we,
    output logic                  is_load,
    output logic [REG_ADDR_W-1:0] rd
);

    // Valid bit: cleared by reset or a bubble, frozen by hold
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (!hold) begin
            vld <= in_vld & ~clear;
        end
    end

    // Payload: follows the upstream stage unless frozen
    always_ff @(posedge clk) begin
        if (!hold) begin
            we      <= in_we;
            is_load <= in_is_load;
            rd      <= in_rd;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core. Mirrors the
// destination info of instructions in EX/MEM/WB, raises load-use stalls,
// applies taken-branch flushes, freezes everything while data memory is busy
// and steers the EX operand forwarding muxes.
// Slot naming: _p0 = EX, _p1 = MEM, _p2 = WB.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_we,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic                  freeze,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel,
    output logic [XLEN-1:0]       stall_cycles,
    output logic [XLEN-1:0]       flush_count
);

    localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

    logic                  vld_p0, we_p0, ld_p0;
    logic [REG_ADDR_W-1:0] rd_p0;
    logic                  vld_p1, we_p1, ld_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic                  vld_p2, we_p2, ld_p2;
    logic [REG_ADDR_W-1:0] rd_p2;

    logic [REG_ADDR_W-1:0] rs1_p0, rs2_p0;
    logic                  rs1_used_p0, rs2_used_p0;

    logic live_p0, live_p1, live_p2;
    logic load_use;
    logic load_fwd_conflict;
    fwd_sel_e fwd1, fwd2;

    // The WB load flag is carried for completeness but no decision needs it
    logic unused_wb_load;
    assign unused_wb_load = ld_p2;

    // Forwarding source for one EX operand; the youngest matching writer wins.
    // A load still in MEM cannot supply data, so it falls back to the regfile.
    function automatic fwd_sel_e pick_fwd(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  mem_live,
        input logic                  mem_ld,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_live,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        if (!used) begin
            return FWD_RF;
        end else if (mem_live && mem_rd == rs) begin
            return mem_ld ? FWD_RF : FWD_MEM;
        end else if (wb_live && wb_rd == rs) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

    // ---- EX slot (p0): loaded from ID, bubbled on stall/flush ----
    hazard_track_slot #(.REG_ADDR_W(REG_ADDR_W)) u_slot_ex (
        .clk        (clk),
        .rst        (rst),
        .hold       (freeze),
        .clear      (bubble_ex),
        .in_vld     (id_valid),
        .in_we      (id_reg_we),
        .in_is_load (id_is_load),
        .in_rd      (id_rd),
        .vld        (vld_p0),
        .we         (we_p0),
        .is_load    (ld_p0),
        .rd         (rd_p0)
    );

    // EX source operands, needed only to steer forwarding
    always_ff @(posedge clk) begin
        if (!freeze) begin
            rs1_p0      <= id_rs1;
            rs2_p0      <= id_rs2;
            rs1_used_p0 <= id_rs1_used;
            rs2_used_p0 <= id_rs2_used;
        end
    end

    // ---- MEM slot (p1) ----
    hazard_track_slot #(.REG_ADDR_W(REG_ADDR_W)) u_slot_mem (
        .clk        (clk),
        .rst        (rst),
        .hold       (freeze),
        .clear      (1'b0),
        .in_vld     (vld_p0),
        .in_we      (we_p0),
        .in_is_load (ld_p0),
        .in_rd      (rd_p0),
        .vld        (vld_p1),
        .we         (we_p1),
        .is_load    (ld_p1),
        .rd         (rd_p1)
    );

    // ---- WB slot (p2) ----
    hazard_track_slot #(.REG_ADDR_W(REG_ADDR_W)) u_slot_wb (
        .clk        (clk),
        .rst        (rst),
        .hold       (freeze),
        .clear      (1'b0),
        .in_vld     (vld_p1),
        .in_we      (we_p1),
        .in_is_load (ld_p1),
        .in_rd      (rd_p1),
        .vld        (vld_p2),
        .we         (we_p2),
        .is_load    (ld_p2),
        .rd         (rd_p2)
    );

    assign live_p0 = vld_p0 & we_p0 & (rd_p0 != X0);
    assign live_p1 = vld_p1 & we_p1 & (rd_p1 != X0);
    assign live_p2 = vld_p2 & we_p2 & (rd_p2 != X0);

    assign load_use = id_valid & live_p0 & ld_p0 &
                      ((id_rs1_used & (id_rs1 == rd_p0)) |
                       (id_rs2_used & (id_rs2 == rd_p0)));

    // Stall/flush/freeze priority: memory freeze, then branch flush, then load-use
    always_comb begin
        freeze      = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (mem_busy) begin
            freeze   = 1'b1;
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // Operand forwarding from held slot state (stays stable through a freeze)
    always_comb begin
        fwd1 = pick_fwd(vld_p0 & rs1_used_p0, rs1_p0, live_p1, ld_p1, rd_p1, live_p2, rd_p2);
        fwd2 = pick_fwd(vld_p0 & rs2_used_p0, rs2_p0, live_p1, ld_p1, rd_p1, live_p2, rd_p2);
    end

    assign fwd_rs1_sel = fwd1;
    assign fwd_rs2_sel = fwd2;

    assign load_fwd_conflict = vld_p0 & live_p1 & ld_p1 &
                               ((rs1_used_p0 & (rs1_p0 == rd_p1)) |
                                (rs2_used_p0 & (rs2_p0 == rd_p1)));

    // Load data in MEM feeding EX means a load-use stall was missed
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!load_fwd_conflict)
                else $error("hazard_ctrl: load in MEM feeds EX operand");
        end
    end

    // Performance counters, wrapping naturally at 2^XLEN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_if) begin
                stall_cycles <= stall_cycles + XLEN'(1);
            end
            if (flush_if_id) begin
                flush_count <= flush_count + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction sequences are driven into ID
// one cycle at a time and the controller outputs are compared with
// hand-derived values.
module tb_hazard_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_rs1_used, id_rs2_used, id_reg_we, id_is_load;
    logic            ex_branch_taken, mem_busy;
    logic            stall_if, stall_id, bubble_ex, flush_if_id, freeze;
    logic [1:0]      fwd_rs1_sel, fwd_rs2_sel;
    logic [XLEN-1:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.XLEN(XLEN), .REG_ADDR_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_reg_we       (id_reg_we),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .freeze          (freeze),
        .fwd_rs1_sel     (fwd_rs1_sel),
        .fwd_rs2_sel     (fwd_rs2_sel),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic si, input logic sd,
                            input logic bx, input logic fl, input logic fz);
        chk({tag, ".stall_if"},    32'(stall_if),    32'(si));
        chk({tag, ".stall_id"},    32'(stall_id),    32'(sd));
        chk({tag, ".bubble_ex"},   32'(bubble_ex),   32'(bx));
        chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(fl));
        chk({tag, ".freeze"},      32'(freeze),      32'(fz));
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] f1, input logic [1:0] f2);
        chk({tag, ".fwd_rs1_sel"}, 32'(fwd_rs1_sel), 32'(f1));
        chk({tag, ".fwd_rs2_sel"}, 32'(fwd_rs2_sel), 32'(f2));
    endtask

    task automatic chk_cnt(input string tag, input int sc, input int fc);
        chk({tag, ".stall_cycles"}, stall_cycles, 32'(sc));
        chk({tag, ".flush_count"},  flush_count,  32'(fc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic id_set(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld);
        id_valid    = 1'b1;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd       = rd;
        id_reg_we   = we;
        id_is_load  = ld;
    endtask

    task automatic id_idle();
        id_valid    = 1'b0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        id_rd       = 5'd0;
        id_reg_we   = 1'b0;
        id_is_load  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
        id_idle();
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk_ctrl("reset", 0, 0, 0, 0, 0);
        chk_fwd("reset", 2'b00, 2'b00);
        chk_cnt("reset", 0, 0);

        // add x5,x1,x2 ; add x6,x5,x3 back-to-back -> MEM forward
        id_set(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        id_set(5'd5, 5'd3, 1, 1, 5'd6, 1, 0);
        settle();
        chk_ctrl("alu_alu_id", 0, 0, 0, 0, 0);
        tick();
        id_idle();
        settle();
        chk_fwd("alu_alu_ex", 2'b01, 2'b00);
        tick();
        tick();
        tick();

        // add x5 ; nop ; add x6,x5,x3 -> WB forward
        id_set(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        id_idle();
        tick();
        id_set(5'd5, 5'd3, 1, 1, 5'd6, 1, 0);
        tick();
        id_idle();
        settle();
        chk_fwd("alu_nop_alu", 2'b10, 2'b00);

        // add x5 ; add x5 ; add x7,x5,x5 -> youngest (MEM) wins over WB
        id_set(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        id_set(5'd3, 5'd4, 1, 1, 5'd5, 1, 0);
        tick();
        id_set(5'd5, 5'd5, 1, 1, 5'd7, 1, 0);
        tick();
        id_idle();
        settle();
        chk_fwd("mem_over_wb", 2'b01, 2'b01);
        tick();
        tick();
        tick();

        // lw x5,0(x1) ; add x6,x5,x2 -> one stall cycle, then WB forward
        id_set(5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        tick();
        id_set(5'd5, 5'd2, 1, 1, 5'd6, 1, 0);
        settle();
        chk_ctrl("load_use", 1, 1, 1, 0, 0);
        chk_cnt("load_use_pre", 0, 0);
        tick();
        settle();
        chk_ctrl("load_use_after", 0, 0, 0, 0, 0);
        chk_cnt("load_use_post", 1, 0);
        tick();
        id_idle();
        settle();
        chk_fwd("load_use_fwd", 2'b10, 2'b00);

        // lw x5 in EX with taken branch, ID reads x5 -> flush beats load-use
        id_set(5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        tick();
        id_set(5'd5, 5'd2, 1, 1, 5'd6, 1, 0);
        ex_branch_taken = 1'b1;
        settle();
        chk_ctrl("branch", 0, 0, 1, 1, 0);
        tick();
        ex_branch_taken = 1'b0;
        id_idle();
        settle();
        chk_cnt("branch_post", 1, 1);
        chk_ctrl("branch_post", 0, 0, 0, 0, 0);

        // lw x7 ; add x3,x1,x2 ; add x4,x3,x7 then freeze 3 cycles
        id_set(5'd1, 5'd0, 1, 0, 5'd7, 1, 1);
        tick();
        id_set(5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        settle();
        chk_ctrl("indep_after_load", 0, 0, 0, 0, 0);
        tick();
        id_set(5'd3, 5'd7, 1, 1, 5'd4, 1, 0);
        settle();
        chk_ctrl("load_in_mem", 0, 0, 0, 0, 0);
        tick();
        id_idle();
        mem_busy = 1'b1;
        settle();
        chk_ctrl("freeze1", 1, 1, 0, 0, 1);
        chk_fwd("freeze1", 2'b01, 2'b10);
        tick();
        ex_branch_taken = 1'b1;
        settle();
        chk_ctrl("freeze2_branch", 1, 1, 0, 0, 1);
        chk_fwd("freeze2", 2'b01, 2'b10);
        chk_cnt("freeze2", 2, 1);
        tick();
        ex_branch_taken = 1'b0;
        settle();
        chk_ctrl("freeze3", 1, 1, 0, 0, 1);
        tick();
        mem_busy = 1'b0;
        settle();
        chk_ctrl("unfreeze", 0, 0, 0, 0, 0);
        chk_fwd("unfreeze", 2'b01, 2'b10);
        chk_cnt("unfreeze", 4, 1);
        tick();

        // addi x0,x0,1 ; add x6,x0,x0 -> never forwarded
        id_set(5'd0, 5'd0, 1, 0, 5'd0, 1, 0);
        tick();
        id_set(5'd0, 5'd0, 1, 1, 5'd6, 1, 0);
        tick();
        id_idle();
        settle();
        chk_fwd("x0_alu", 2'b00, 2'b00);

        // lw x0 ; add x6,x0,x0 -> no stall, no forward
        id_set(5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
        tick();
        id_set(5'd0, 5'd0, 1, 1, 5'd6, 1, 0);
        settle();
        chk_ctrl("x0_load", 0, 0, 0, 0, 0);
        tick();
        id_idle();
        settle();
        chk_fwd("x0_load_fwd", 2'b00, 2'b00);
        chk_cnt("x0_load", 4, 1);
        tick();
        tick();

        // reset asserted during a load-use stall cycle
        id_set(5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        tick();
        id_set(5'd5, 5'd2, 1, 1, 5'd6, 1, 0);
        rst = 1'b1;
        settle();
        chk_ctrl("rst_in_stall", 1, 1, 1, 0, 0);
        tick();
        rst = 1'b0;
        settle();
        chk_ctrl("after_rst", 0, 0, 0, 0, 0);
        chk_fwd("after_rst", 2'b00, 2'b00);
        chk_cnt("after_rst", 0, 0);
        tick();
        id_idle();
        settle();
        chk_fwd("after_rst_ex", 2'b00, 2'b00);
        chk_ctrl("after_rst_ex", 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
